uart_rx: RTL and testbench

Serial receiver paired with the UART transmitter: it recovers 8-bit frames (1 start bit, 8 data bits LSB first, 1 stop bit, optional parity) from an asynchronous serial line. It is the downstream stage of the TX block. Its input connects to the far-end TX serial output, or to the local TX output for loopback. Each received byte is presented on a one-cycle valid strobe to the consumer logic. Line errors are flagged on one-cycle strobes and are never delivered as data.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and RX state encoding
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = RX_IDLE,
        S_START  = RX_START,
        S_DATA   = RX_DATA,
        S_PARITY = RX_PARITY,
        S_STOP   = RX_STOP,
        S_BREAK  = RX_BREAK
    } rx_state_t;

    // Value of the even-parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer with configurable reset level
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst)
            ff <= {2{RESET_VAL}};
        else
            ff <= {ff[0], d};
    end

    assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 or 8E1 frames, mid-bit sampling
// Optional even parity compiled in with UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk (i_Clock),
        .rst (i_Rst_L),
        .d   (i_RX_Serial),
        .q   (rx_s)
    );

    rx_state_t      state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shreg, shreg_n;
    logic [7:0]     rx_byte, rx_byte_n;
    logic           dv, dv_n;
    logic           ferr, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic           par_bad, par_bad_n;
    logic           perr, perr_n;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Rst_L) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            rx_byte <= '0;
            dv      <= 1'b0;
            ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            rx_byte <= rx_byte_n;
            dv      <= dv_n;
            ferr    <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr    <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        rx_byte_n = rx_byte;
        dv_n      = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                if (rx_s == START_BIT)
                    state_n = S_START;
            end
            // A start bit that rises before mid-bit is a glitch; drop it at once.
            S_START: begin
                if (rx_s != START_BIT) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt == HALF) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == LAST_IDX) begin
                        idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    par_bad_n = (rx_s != even_parity(shreg));
                    state_n   = S_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
            S_STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s == STOP_BIT) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            dv_n      = 1'b1;
                            rx_byte_n = shreg;
                        end
`else
                        dv_n      = 1'b1;
                        rx_byte_n = shreg;
`endif
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s == LINE_IDLE)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign o_RX_DV        = dv;
    assign o_RX_Byte      = rx_byte;
    assign o_RX_Frame_Err = ferr;
    assign o_RX_Active    = (state == S_START) || (state == S_DATA) ||
                            (state == S_PARITY) || (state == S_STOP);
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = perr;
`else
    assign o_RX_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Edge at which the receiver decides the stop bit, counted from the start-bit edge.
    localparam int LAT = 4 + HALF + NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       dv;
    logic [7:0] rbyte;
    logic       active;
    logic       ferr;
    logic       perr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock         (clk),
        .i_Rst_L         (rst),
        .i_RX_Serial     (rx),
        .o_RX_DV         (dv),
        .o_RX_Byte       (rbyte),
        .o_RX_Active     (active),
        .o_RX_Frame_Err  (ferr),
        .o_RX_Parity_Err (perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    logic [7:0] dv_bytes[$];
    int         dv_times[$];
    int         ferr_times[$];
    int         n_ferr = 0, n_perr = 0, n_overlap = 0, n_wide = 0, n_bytechg = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clk) begin
        if (dv) begin
            dv_bytes.push_back(rbyte);
            dv_times.push_back(cyc);
        end
        if (ferr) begin
            n_ferr++;
            ferr_times.push_back(cyc);
        end
        if (perr) n_perr++;
        if (int'(dv) + int'(ferr) + int'(perr) > 1) n_overlap++;
        if (prev_strobe && (dv || ferr || perr)) n_wide++;
        if (rbyte !== prev_byte && !dv && !rst_q) n_bytechg++;
        prev_strobe = dv || ferr || perr;
        prev_byte   = rbyte;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, output int t0);
        logic bits[$];
        logic pbit;
        pbit = (^data) ^ par_flip;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(pbit);
`endif
        bits.push_back(stop_bit);
        t0 = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    int         t0, t1, base_dv, base_ferr, base_perr, run, maxrun;
    logic [7:0] last_good;
    logic [7:0] exp_bytes[$];
    int         exp_times[$];

    initial begin
        // Reset with idle line.
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset_dv",     32'(dv), 32'd0);
        check("reset_byte",   32'(rbyte), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        check("reset_ferr",   32'(ferr), 32'd0);
        check("reset_perr",   32'(perr), 32'd0);
        idle(1);
        check("release_no_strobe", 32'(dv | ferr | perr), 32'd0);
        idle(5);

        // Single nominal frame.
        base_dv = dv_bytes.size(); base_ferr = n_ferr; base_perr = n_perr;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle(2 * CPB);
        check("a5_count", 32'(dv_bytes.size() - base_dv), 32'd1);
        if (dv_bytes.size() > base_dv) begin
            check("a5_byte", 32'(dv_bytes[base_dv]), 32'hA5);
            check("a5_time", 32'(dv_times[base_dv]), 32'(t0 + LAT));
        end
        check("a5_noerr", 32'(n_ferr - base_ferr + n_perr - base_perr), 32'd0);
        check("a5_held", 32'(rbyte), 32'hA5);

        // Back-to-back frames, no idle gap.
        base_dv = dv_bytes.size();
        send_frame(8'h00, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 1'b1, 1'b0, t1);
        idle(2 * CPB);
        check("b2b_count", 32'(dv_bytes.size() - base_dv), 32'd2);
        if (dv_bytes.size() >= base_dv + 2) begin
            check("b2b_byte0", 32'(dv_bytes[base_dv]), 32'h00);
            check("b2b_byte1", 32'(dv_bytes[base_dv + 1]), 32'hFF);
            check("b2b_time0", 32'(dv_times[base_dv]), 32'(t0 + LAT));
            check("b2b_spacing", 32'(dv_times[base_dv + 1] - dv_times[base_dv]), 32'((NB + 1) * CPB));
        end
        last_good = 8'hFF;

        // Short glitch on the line.
        base_dv = dv_bytes.size(); base_ferr = n_ferr; base_perr = n_perr;
        rx = 1'b0; run = 0; maxrun = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 4) rx = 1'b1;
            @(posedge clk);
            #1;
            run = active ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("glitch_no_strobe", 32'(dv_bytes.size() - base_dv + n_ferr - base_ferr + n_perr - base_perr), 32'd0);
        check("glitch_active_short", 32'(maxrun >= 1 && maxrun <= 5), 32'd1);
        check("glitch_idle", 32'(active), 32'd0);

        // Bad stop bit followed by a held-low line.
        base_dv = dv_bytes.size(); base_ferr = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        idle(100);
        check("break_active_low", 32'(active), 32'd0);
        check("break_ferr_once", 32'(n_ferr - base_ferr), 32'd1);
        if (n_ferr > base_ferr)
            check("break_ferr_time", 32'(ferr_times[base_ferr]), 32'(t0 + LAT));
        check("break_no_dv", 32'(dv_bytes.size() - base_dv), 32'd0);
        check("break_byte_held", 32'(rbyte), 32'(last_good));
        rx = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0, t0);
        idle(2 * CPB);
        check("after_break_count", 32'(dv_bytes.size() - base_dv), 32'd1);
        if (dv_bytes.size() > base_dv)
            check("after_break_byte", 32'(dv_bytes[base_dv]), 32'h81);
        check("after_break_ferr", 32'(n_ferr - base_ferr), 32'd1);

        // Reset for one cycle in the middle of data bit 3.
        begin
            logic [7:0] d;
            d = 8'h5A;
            rx = 1'b0;
            idle(CPB);
            for (int i = 0; i < 3; i++) begin
                rx = d[i];
                idle(CPB);
            end
            rx = d[3];
            idle(CPB / 2);
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            check("midrst_dv",     32'(dv), 32'd0);
            check("midrst_byte",   32'(rbyte), 32'd0);
            check("midrst_active", 32'(active), 32'd0);
            check("midrst_errs",   32'(ferr | perr), 32'd0);
            rx = 1'b1;
            idle(1);
            check("midrst_release", 32'(dv | ferr | perr), 32'd0);
            idle(40);
            base_dv = dv_bytes.size(); base_ferr = n_ferr;
            send_frame(d, 1'b1, 1'b0, t0);
            idle(2 * CPB);
            check("midrst_count", 32'(dv_bytes.size() - base_dv), 32'd1);
            if (dv_bytes.size() > base_dv)
                check("midrst_byte_5a", 32'(dv_bytes[base_dv]), 32'h5A);
            check("midrst_noerr", 32'(n_ferr - base_ferr), 32'd0);
        end

        // Random bytes with random inter-frame gaps, including none.
        base_dv = dv_bytes.size(); base_ferr = n_ferr; base_perr = n_perr;
        exp_bytes = {}; exp_times = {};
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            int gap;
            d   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 24);
            send_frame(d, 1'b1, 1'b0, t0);
            exp_bytes.push_back(d);
            exp_times.push_back(t0 + LAT);
            rx = 1'b1;
            if (gap > 0) idle(gap);
        end
        idle(2 * CPB);
        check("rand_count", 32'(dv_bytes.size() - base_dv), 32'(exp_bytes.size()));
        foreach (exp_bytes[k]) begin
            if (base_dv + k < dv_bytes.size()) begin
                check($sformatf("rand_byte%0d", k), 32'(dv_bytes[base_dv + k]), 32'(exp_bytes[k]));
                check($sformatf("rand_time%0d", k), 32'(dv_times[base_dv + k]), 32'(exp_times[k]));
            end
        end
        check("rand_noerr", 32'(n_ferr - base_ferr + n_perr - base_perr), 32'd0);
        if (exp_bytes.size() > 0) last_good = exp_bytes[exp_bytes.size() - 1];

`ifdef UART_RX_PARITY_EN
        base_dv = dv_bytes.size(); base_perr = n_perr;
        send_frame(8'h07, 1'b1, 1'b0, t0);
        idle(2 * CPB);
        check("par_ok_count", 32'(dv_bytes.size() - base_dv), 32'd1);
        if (dv_bytes.size() > base_dv) begin
            check("par_ok_byte", 32'(dv_bytes[base_dv]), 32'h07);
            check("par_ok_time", 32'(dv_times[base_dv]), 32'(t0 + LAT));
        end
        check("par_ok_noerr", 32'(n_perr - base_perr), 32'd0);
        base_dv = dv_bytes.size(); base_perr = n_perr; base_ferr = n_ferr;
        send_frame(8'h07, 1'b1, 1'b1, t0);
        idle(2 * CPB);
        check("par_bad_perr", 32'(n_perr - base_perr), 32'd1);
        check("par_bad_no_dv", 32'(dv_bytes.size() - base_dv), 32'd0);
        check("par_bad_no_ferr", 32'(n_ferr - base_ferr), 32'd0);
        check("par_bad_byte_held", 32'(rbyte), 32'h07);
`else
        check("perr_tied_low", 32'(n_perr), 32'd0);
`endif

        check("strobes_exclusive", 32'(n_overlap), 32'd0);
        check("strobes_one_cycle", 32'(n_wide), 32'd0);
        check("byte_only_on_dv", 32'(n_bytechg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
